// File: rtl/pulse_meas_scheduler.sv
// Purpose : round-robin sharing of one pulse-width measurement engine across CH channels.
// Latency : grant 1 cycle after req in IDLE; 2 arm cycles, then wait for low/rise, width, +1 to result.
// Backpr. : result held in REPORT while res_ready is low; no new grant is issued until it is accepted.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in[CH]           per-channel pulse inputs (only the granted one is observed)
//   req[CH]          per-channel measurement request (level, sampled only in IDLE)
//   grant[CH]        one-hot grant, held from ARM through REPORT
//   busy             high whenever the engine is not idle
//   res_valid/ready  result handshake
//   res_ch           index of the measured channel
//   res_width        measured high width in cycles, saturating (0 on timeout)
//   res_long         res_width >= 3*NUM (saturated width counts as long)
//   res_timeout      measurement aborted waiting for low level / rising edge
module pulse_meas_scheduler #(
  parameter int CH      = 4,
  parameter int NUM     = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         in,
  input  logic [CH-1:0]         req,
  output logic [CH-1:0]         grant,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [$clog2(CH)-1:0] res_ch,
  output logic [CNT_W-1:0]      res_width,
  output logic                  res_long,
  output logic                  res_timeout
);

  localparam int IDX_W   = $clog2(CH);
  // Holds TIMEOUT+1: a low level found exactly at the limit still gets one rise check.
  localparam int TMO_W   = $clog2(TIMEOUT + 2);
  localparam int LONG_TH = 3 * NUM;
  localparam logic [CNT_W-1:0] WIDTH_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_LOW,
    S_WAIT_RISE,
    S_MEASURE,
    S_REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr, sel, pick_idx;
  logic             pick_found;
  int               cand;
  logic             s1, s2, arm_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] width;
  logic             tmo_hit, rise, fall, width_long;
  logic             arm_go, meas_start, rep_meas, rep_tmo, accept, tmo_inc;

  // Rotating-priority pick: scan from the highest offset down so the
  // lowest offset from rr_ptr with a set request is the one that sticks.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = CH - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= CH) cand = cand - CH;
      if (req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Edge detect on the two sample flops. In WAIT_RISE s2 is always 0 on entry
  // and in MEASURE s2 is always 1, so these reduce to plain level checks there.
  assign rise       = s1 & ~s2;
  assign fall       = ~s1 & s2;
  assign tmo_hit    = (tmo_cnt >= TMO_W'(TIMEOUT));
  assign width_long = (int'(width) >= LONG_TH) || (width == WIDTH_MAX);

  always_comb begin
    state_d    = state_q;
    arm_go     = 1'b0;
    meas_start = 1'b0;
    rep_meas   = 1'b0;
    rep_tmo    = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_ARM;
          arm_go  = 1'b1;
        end
      end
      S_ARM: begin
        if (arm_cnt) state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        // A qualifying event on the timeout cycle takes precedence.
        if (!s1) begin
          state_d = S_WAIT_RISE;
        end else if (tmo_hit) begin
          state_d = S_REPORT;
          rep_tmo = 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (rise) begin
          state_d    = S_MEASURE;
          meas_start = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_REPORT;
          rep_tmo = 1'b1;
        end
      end
      S_MEASURE: begin
        if (fall) begin
          state_d  = S_REPORT;
          rep_meas = 1'b1;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          state_d = S_IDLE;
          accept  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The timeout budget spans both wait states without restarting.
  assign tmo_inc = (state_q == S_WAIT_LOW || state_q == S_WAIT_RISE) &&
                   (state_d == S_WAIT_LOW || state_d == S_WAIT_RISE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr      <= '0;
      sel         <= '0;
      grant       <= '0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      arm_cnt     <= 1'b0;
      tmo_cnt     <= '0;
      width       <= '0;
      res_width   <= '0;
      res_long    <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      state_q <= state_d;

      if (arm_go) begin
        sel     <= pick_idx;
        grant   <= CH'(1) << pick_idx;
        s1      <= 1'b0;
        s2      <= 1'b0;
        arm_cnt <= 1'b0;
        width   <= '0;
      end else begin
        s1 <= in[sel];
        s2 <= s1;
      end

      if (state_q == S_ARM) begin
        arm_cnt <= 1'b1;
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      if (meas_start) begin
        width <= CNT_W'(1);
      end else if (state_q == S_MEASURE && s1 && width != WIDTH_MAX) begin
        width <= width + CNT_W'(1);
      end

      if (rep_meas) begin
        res_width   <= width;
        res_long    <= width_long;
        res_timeout <= 1'b0;
      end else if (rep_tmo) begin
        res_width   <= '0;
        res_long    <= 1'b0;
        res_timeout <= 1'b1;
      end

      if (accept) begin
        grant  <= '0;
        rr_ptr <= (sel == IDX_W'(CH - 1)) ? '0 : sel + IDX_W'(1);
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_REPORT);
  assign res_ch    = sel;

endmodule
